// File: rtl/gmii_rx.sv
// GMII receive path: SFD hunt, MAC/IP/UDP filter, video/audio payload split.
// Define RX_CRC_CHECK_EN to verify the Ethernet FCS before signalling frame_done.
module gmii_rx #(
  parameter logic [47:0] own_mac       = 48'h002345678902,
  parameter logic [15:0] udp_port      = 16'h3039,
  parameter logic [10:0] max_vid_pairs = 11'd640
) (
  input  logic        rx_clk,
  input  logic        sys_rst,
  input  logic        id,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  input  logic        vid_full,
  output logic        vid_wr_en,
  output logic [31:0] vid_din,
  input  logic        aux_full,
  output logic        aux_wr_en,
  output logic [7:0]  aux_din,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] drop_cnt
);

  typedef enum logic [3:0] {
    S_WAIT, S_IDLE, S_PRE, S_HDR, S_IDENT,
    S_VHDR, S_VDATA, S_ADATA, S_TAIL, S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [15:0] ulen_q, ulen_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] hdr_q, hdr_d;
  logic [7:0]  y_q, y_d;
  logic        ph_q, ph_d;
  logic [10:0] pairs_q, pairs_d;
  logic [15:0] drop_q, drop_d;
  logic        vwr_q, vwr_d;
  logic [31:0] vdin_q, vdin_d;
  logic        awr_q, awr_d;
  logic [7:0]  adin_q, adin_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        inc, abort, hdr_ok;
  logic [7:0]  mac_lo;

`ifdef RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d;

  // Bits enter LSB first, as on the wire; good frames leave the magic residue.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction
`endif

  assign mac_lo = own_mac[7:0] - {7'd0, id};

  always_comb begin
    hdr_ok = 1'b1;
    case (idx_q)
      6'd0:    hdr_ok = (rxd == own_mac[47:40]);
      6'd1:    hdr_ok = (rxd == own_mac[39:32]);
      6'd2:    hdr_ok = (rxd == own_mac[31:24]);
      6'd3:    hdr_ok = (rxd == own_mac[23:16]);
      6'd4:    hdr_ok = (rxd == own_mac[15:8]);
      6'd5:    hdr_ok = (rxd == mac_lo);
      6'd12:   hdr_ok = (rxd == 8'h08);
      6'd13:   hdr_ok = (rxd == 8'h00);
      6'd23:   hdr_ok = (rxd == 8'h11);
      6'd36:   hdr_ok = (rxd == udp_port[15:8]);
      6'd37:   hdr_ok = (rxd == udp_port[7:0]);
      default: hdr_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ulen_d  = ulen_q;
    rem_d   = rem_q;
    hdr_d   = hdr_q;
    y_d     = y_q;
    ph_d    = ph_q;
    pairs_d = pairs_q;
    vwr_d   = 1'b0;
    vdin_d  = vdin_q;
    awr_d   = 1'b0;
    adin_d  = adin_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    inc     = 1'b0;
    abort   = 1'b0;
`ifdef RX_CRC_CHECK_EN
    crc_d = crc_q;
    if (state_q == S_PRE)
      crc_d = 32'hFFFFFFFF;
    else if (rx_dv && state_q inside {S_HDR, S_IDENT, S_VHDR,
                                      S_VDATA, S_ADATA, S_TAIL})
      crc_d = crc_step(crc_q, rxd);
`endif
    unique case (state_q)
      S_WAIT: if (!rx_dv) state_d = S_IDLE;
      S_IDLE: if (rx_dv && rxd == 8'h55) state_d = S_PRE;
      S_PRE: begin
        if (!rx_dv) state_d = S_WAIT;
        else if (rxd == 8'hD5) begin
          state_d = S_HDR;
          idx_d   = 6'd0;
        end else if (rxd != 8'h55) state_d = S_WAIT;
      end
      S_HDR: begin
        if (!rx_dv) abort = 1'b1;
        else if (!hdr_ok) begin
          state_d = S_DROP;
          inc     = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd38) ulen_d[15:8] = rxd;
          if (idx_q == 6'd39) begin
            ulen_d[7:0] = rxd;
            if ({ulen_q[15:8], rxd} < 16'd11) begin
              state_d = S_DROP;
              inc     = 1'b1;
            end
          end
          if (idx_q == 6'd41) state_d = S_IDENT;
        end
      end
      S_IDENT: begin
        rem_d   = ulen_q - 16'd9;
        idx_d   = 6'd0;
        pairs_d = 11'd0;
        if (!rx_dv) abort = 1'b1;
        else if (rxd == 8'h00) state_d = S_VHDR;
        else if (rxd == 8'h01) state_d = S_ADATA;
        else begin
          state_d = S_DROP;
          inc     = 1'b1;
        end
      end
      S_VHDR: begin
        if (!rx_dv) abort = 1'b1;
        else if (!idx_q[0]) begin
          hdr_d[15:8] = rxd;
          idx_d       = 6'd1;
        end else begin
          hdr_d[7:0] = rxd;
          rem_d      = rem_q - 16'd2;
          ph_d       = 1'b0;
          state_d    = (rem_q == 16'd2) ? S_TAIL : S_VDATA;
        end
      end
      S_VDATA: begin
        if (!rx_dv) abort = 1'b1;
        else begin
          rem_d = rem_q - 16'd1;
          ph_d  = ~ph_q;
          if (!ph_q) y_d = rxd;
          else if (!vid_full && pairs_q < max_vid_pairs) begin
            vwr_d   = 1'b1;
            vdin_d  = {hdr_q, y_q, rxd};
            pairs_d = pairs_q + 11'd1;
          end
          if (rem_q == 16'd1) state_d = S_TAIL;
        end
      end
      S_ADATA: begin
        if (!rx_dv) abort = 1'b1;
        else begin
          rem_d = rem_q - 16'd1;
          if (!aux_full) begin
            awr_d  = 1'b1;
            adin_d = rxd;
          end
          if (rem_q == 16'd1) state_d = S_TAIL;
        end
      end
      S_TAIL: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
`ifdef RX_CRC_CHECK_EN
          if (crc_q == 32'hC704DD7B) done_d = 1'b1;
          else begin
            err_d = 1'b1;
            inc   = 1'b1;
          end
`else
          done_d = 1'b1;
`endif
        end
      end
      S_DROP: if (!rx_dv) state_d = S_IDLE;
      default: state_d = S_WAIT;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      inc     = 1'b1;
    end
    // A coding error discards the byte and forces a resync at the next gap.
    if (rx_er && state_q inside {S_PRE, S_HDR, S_IDENT, S_VHDR,
                                 S_VDATA, S_ADATA, S_TAIL}) begin
      state_d = S_WAIT;
      vwr_d   = 1'b0;
      awr_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      inc     = 1'b1;
    end
    drop_d = (inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge rx_clk) begin
    if (sys_rst) begin
      state_q <= S_WAIT;
      idx_q   <= '0;
      ulen_q  <= '0;
      rem_q   <= '0;
      hdr_q   <= '0;
      y_q     <= '0;
      ph_q    <= 1'b0;
      pairs_q <= '0;
      drop_q  <= '0;
      vwr_q   <= 1'b0;
      vdin_q  <= '0;
      awr_q   <= 1'b0;
      adin_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc_q   <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ulen_q  <= ulen_d;
      rem_q   <= rem_d;
      hdr_q   <= hdr_d;
      y_q     <= y_d;
      ph_q    <= ph_d;
      pairs_q <= pairs_d;
      drop_q  <= drop_d;
      vwr_q   <= vwr_d;
      vdin_q  <= vdin_d;
      awr_q   <= awr_d;
      adin_q  <= adin_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef RX_CRC_CHECK_EN
      crc_q   <= crc_d;
`endif
    end
  end

  assign vid_wr_en  = vwr_q;
  assign vid_din    = vdin_q;
  assign aux_wr_en  = awr_q;
  assign aux_din    = adin_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_gmii_rx.sv
// Directed + randomized frames for gmii_rx against a queue-based payload model.
module tb_gmii_rx;

  logic        clk = 1'b0;
  logic        rst, id, rx_dv, rx_er, vid_full, aux_full;
  logic [7:0]  rxd;
  logic        vid_wr_en, aux_wr_en, frame_done, frame_err;
  logic [31:0] vid_din;
  logic [7:0]  aux_din;
  logic [15:0] drop_cnt;

  gmii_rx dut (
    .rx_clk(clk), .sys_rst(rst), .id(id), .rx_dv(rx_dv), .rx_er(rx_er),
    .rxd(rxd), .vid_full(vid_full), .vid_wr_en(vid_wr_en),
    .vid_din(vid_din), .aux_full(aux_full), .aux_wr_en(aux_wr_en),
    .aux_din(aux_din), .frame_done(frame_done), .frame_err(frame_err),
    .drop_cnt(drop_cnt)
  );

  always #4 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int n_done, n_err, first_wr, lat_idx, lat_cyc, exp_drop;
  logic [31:0] vq[$], vexp[$];
  logic [7:0]  aq[$], aexp[$], frm[$];
  bit          fq[$], afq[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (vid_wr_en) begin
      if (vq.size() == 0) first_wr = cyc;
      vq.push_back(vid_din);
    end
    if (aux_wr_en) aq.push_back(aux_din);
    if (frame_done) n_done++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    vq.delete(); vexp.delete(); aq.delete(); aexp.delete();
    n_done = 0; n_err = 0; first_wr = -1; lat_idx = -1; lat_cyc = -1;
  endtask

  task automatic drive(input bit dv, input logic [7:0] d, input bit er);
    rx_dv = dv; rxd = d; rx_er = er;
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [7:0] b, input bit vf, input bit af);
    frm.push_back(b); fq.push_back(vf); afq.push_back(af);
  endtask

  task automatic rnd(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom), 0, 0);
  endtask

  task automatic hdr(input logic [7:0] maclo, input logic [15:0] port,
                     input logic [15:0] ulen);
    logic [15:0] tl;
    frm.delete(); fq.delete(); afq.delete();
    tl = ulen + 16'd20;
    put(8'h00, 0, 0); put(8'h23, 0, 0); put(8'h45, 0, 0);
    put(8'h67, 0, 0); put(8'h89, 0, 0); put(maclo, 0, 0);
    rnd(6);
    put(8'h08, 0, 0); put(8'h00, 0, 0);
    put(8'h45, 0, 0); put(8'h00, 0, 0); put(tl[15:8], 0, 0);
    put(tl[7:0], 0, 0); rnd(4); put(8'h40, 0, 0); put(8'h11, 0, 0);
    rnd(10);
    rnd(2); put(port[15:8], 0, 0); put(port[7:0], 0, 0);
    put(ulen[15:8], 0, 0); put(ulen[7:0], 0, 0); rnd(2);
  endtask

  // Video payload: ident, line header, nb pixel bytes. mode 0: Y=i, C=~i.
  task automatic vid_pay(input logic [15:0] lh, input int nb, input int mode,
                         input int flo, input int fhi);
    logic [7:0] y, c;
    bit vf;
    int written = 0;
    put(8'h00, 0, 0); put(lh[15:8], 0, 0); put(lh[7:0], 0, 0);
    for (int p = 0; p < nb / 2; p++) begin
      y = (mode == 0) ? 8'(p) : 8'($urandom);
      c = (mode == 0) ? ~y : 8'($urandom);
      vf = (p >= flo && p <= fhi);
      put(y, vf, 0); put(c, vf, 0);
      if (!vf && written < 640) begin
        vexp.push_back({lh, y, c});
        written++;
      end
    end
    if (nb % 2 == 1) put(8'($urandom), 0, 0);
  endtask

  task automatic aud_pay(input int nb, input bit rfull);
    logic [7:0] b;
    bit af;
    put(8'h01, 0, 0);
    for (int i = 0; i < nb; i++) begin
      b = 8'($urandom);
      af = rfull ? bit'($urandom_range(0, 3) == 0) : 1'b0;
      put(b, 0, af);
      if (!af) aexp.push_back(b);
    end
  endtask

  function automatic logic [31:0] fcs_of();
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (frm[i]) begin
      c ^= {24'h0, frm[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send(input bit bad_fcs, input int cut, input int er_at);
    logic [31:0] f;
    f = fcs_of();
    if (bad_fcs) f[31:24] = f[31:24] ^ 8'h10;
    put(f[7:0], 0, 0); put(f[15:8], 0, 0);
    put(f[23:16], 0, 0); put(f[31:24], 0, 0);
    repeat (7) drive(1, 8'h55, 0);
    drive(1, 8'hD5, 0);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == cut) break;
      vid_full = fq[i]; aux_full = afq[i];
      if (i == lat_idx) lat_cyc = cyc;
      drive(1, frm[i], i == er_at);
    end
    vid_full = 0; aux_full = 0;
    repeat (8) drive(0, 8'h00, 0);
  endtask

  task automatic chk_vid(input string tag);
    int nm = 0;
    chk({tag, "_nwr"}, vq.size(), vexp.size());
    foreach (vexp[i]) if (i >= vq.size() || vq[i] !== vexp[i]) nm++;
    chk({tag, "_data"}, nm, 0);
  endtask

  task automatic chk_aud(input string tag);
    int nm = 0;
    chk({tag, "_nwr"}, aq.size(), aexp.size());
    foreach (aexp[i]) if (i >= aq.size() || aq[i] !== aexp[i]) nm++;
    chk({tag, "_data"}, nm, 0);
  endtask

  task automatic chk_end(input string tag, input int d, input int e);
    chk({tag, "_done"}, n_done, d);
    chk({tag, "_err"}, n_err, e);
    chk({tag, "_drop"}, drop_cnt, exp_drop);
  endtask

  initial begin
    rst = 1; id = 0; rx_dv = 0; rx_er = 0; rxd = 0;
    vid_full = 0; aux_full = 0; exp_drop = 0;
    clr();
    repeat (3) drive(0, 8'h00, 0);
    chk("rst_vwr", vid_wr_en, 0);
    chk("rst_vdin", vid_din, 0);
    chk("rst_awr", aux_wr_en, 0);
    chk("rst_adin", aux_din, 0);
    chk("rst_flags", {frame_done, frame_err}, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 0;
    repeat (2) drive(0, 8'h00, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd1291);
    vid_pay(16'h0123, 1280, 0, -1, -1);
    lat_idx = 46;
    send(0, -1, -1);
    chk_vid("vid");
    chk("vid_first", vq.size() > 0 ? vq[0] : 32'hx, 32'h012300FF);
    chk("vid_latency", first_wr, lat_cyc + 1);
    chk_end("vid", 1, 0);

    clr(); hdr(8'h03, 16'h3039, 16'd1291);
    vid_pay(16'h0123, 1280, 0, -1, -1);
    vexp.delete(); exp_drop++;
    send(0, -1, -1);
    chk_vid("badmac"); chk_end("badmac", 0, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd41); aud_pay(32, 0);
    send(0, -1, -1);
    chk_aud("aud"); chk_end("aud", 1, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd1291);
    vid_pay(16'h0123, 1280, 0, 10, 19);
    send(0, -1, -1);
    chk_vid("vfull");
    chk("vfull_p20", vq.size() > 10 ? vq[10] : 32'hx, 32'h012314EB);
    chk_end("vfull", 1, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd1291);
    vid_pay(16'h0456, 1280, 1, -1, -1);
    while (vexp.size() > 50) void'(vexp.pop_back());
    exp_drop++;
    send(0, 145, -1);
    chk_vid("cut"); chk_end("cut", 0, 1);

    clr(); hdr(8'h02, 16'h3039, 16'd1291);
    vid_pay(16'h0789, 1280, 1, -1, -1);
    send(0, -1, -1);
    chk_vid("after_cut"); chk_end("after_cut", 1, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd41); aud_pay(32, 1);
`ifdef RX_CRC_CHECK_EN
    exp_drop++;
    send(1, -1, -1);
    chk_aud("badfcs"); chk_end("badfcs", 0, 1);
`else
    send(1, -1, -1);
    chk_aud("badfcs"); chk_end("badfcs", 1, 0);
`endif

    id = 1;
    clr(); hdr(8'h01, 16'h3039, 16'd41); aud_pay(32, 1);
    send(0, -1, -1);
    chk_aud("id1"); chk_end("id1", 1, 0);
    clr(); hdr(8'h02, 16'h3039, 16'd41); aud_pay(32, 0);
    aexp.delete(); exp_drop++;
    send(0, -1, -1);
    chk_aud("id1_bad"); chk_end("id1_bad", 0, 0);
    id = 0;

    clr(); hdr(8'h02, 16'h3040, 16'd41); aud_pay(32, 0);
    aexp.delete(); exp_drop++;
    send(0, -1, -1);
    chk_aud("badport"); chk_end("badport", 0, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd10); vid_pay(16'h1111, 4, 1, -1, -1);
    vexp.delete(); exp_drop++;
    send(0, -1, -1);
    chk_vid("ulen10"); chk_end("ulen10", 0, 0);
    for (int u = 11; u <= 14; u++) begin
      clr(); hdr(8'h02, 16'h3039, 16'(u));
      vid_pay(16'h2222, u - 11, 1, -1, -1);
      send(0, -1, -1);
      chk_vid("ulen_small"); chk_end("ulen_small", 1, 0);
    end

    clr(); hdr(8'h02, 16'h3039, 16'd1411);
    vid_pay(16'h0ABC, 1400, 1, 3, 5);
    send(0, -1, -1);
    chk_vid("cap"); chk_end("cap", 1, 0);

    clr(); hdr(8'h02, 16'h3039, 16'd1291);
    vid_pay(16'h0321, 1280, 1, -1, -1);
    while (vexp.size() > 20) void'(vexp.pop_back());
    exp_drop++;
    send(0, -1, 85);
    chk_vid("rxer"); chk_end("rxer", 0, 1);

    for (int k = 0; k < 3; k++) begin
      int nb;
      nb = $urandom_range(2, 60);
      clr(); hdr(8'h02, 16'h3039, 16'(nb + 9)); aud_pay(nb, 1);
      send(0, -1, -1);
      chk_aud("rand_aud"); chk_end("rand_aud", 1, 0);
    end

    rst = 1; drive(0, 8'h00, 0); rst = 0;
    chk("rst2_drop", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmii_rx.md
Name: gmii_rx

Overview:
- Receive-side counterpart of the GMII UDP video/audio transmitter.
- Takes a raw GMII byte stream from the PHY and finds the start-of-frame delimiter (SFD).
- Filters frames by MAC, ethertype, IP protocol and UDP port, then splits the payload by packet ident byte:
  - video: line header plus Y/C pixel pairs, written to the video FIFO;
  - audio: raw bytes, written to the aux FIFO.
- Sits between the PHY RX pins and the HDMI output-side FIFOs.

Parameters:
- own_mac, 48'h002345678902, local MAC; low byte is compared after subtracting id.
- udp_port, 16'h3039, accepted UDP destination port.
- max_vid_pairs, 11'd640, cap on video pairs written per frame.

Ports:
- rx_clk  in  1  GMII receive clock, 125 MHz; the only clock.
- sys_rst  in  1  reset, synchronous, active-high.
- id  in  1  board id; expected dst MAC low byte = own_mac[7:0] - id.
- rx_dv  in  1  GMII data valid.
- rx_er  in  1  GMII receive error.
- rxd  in  8  GMII receive data.
- vid_full  in  1  video FIFO full.
- vid_wr_en  out  1  video FIFO write strobe.
- vid_din  out  32  {line_hdr[15:0], y_byte, c_byte}.
- aux_full  in  1  aux FIFO full.
- aux_wr_en  out  1  aux FIFO write strobe.
- aux_din  out  8  audio payload byte.
- frame_done  out  1  one-cycle pulse: accepted frame ended cleanly.
- frame_err  out  1  one-cycle pulse: accepted frame aborted or had an error.
- drop_cnt  out  16  saturating count of filtered-out or aborted frames.

Behaviour:
- Reset (sync, sys_rst=1): all outputs 0, state WAIT_IDLE, counters 0.
- WAIT_IDLE: holds until rx_dv=0 for 1 cycle, then IDLE. Guarantees a reset or abort mid-frame never resyncs inside a frame.
- IDLE: rx_dv=1 and rxd=8'h55 -> PRE.
- PRE:
  - rxd=8'hD5 -> HDR with byte count=0.
  - rxd=8'h55 stays in PRE.
  - any other byte, or rx_dv=0 -> WAIT_IDLE (no count).
- HDR: 42 bytes (Ethernet 14, IP 20, UDP 8), byte index 0..41. Checks:
  - dst MAC (idx 0-5) = own_mac with low byte - id;
  - ethertype (12-13) = 16'h0800;
  - IP protocol (23) = 8'h11;
  - UDP dst port (36-37) = udp_port.
  - Latch UDP length (38-39) as ulen.
  - Any mismatch -> DROP; drop_cnt+1, saturating at 16'hFFFF.
  - ulen < 11 -> DROP.
  - After idx 41 -> IDENT.
- IDENT:
  - 8'h00 -> VHDR; remaining = ulen-9.
  - 8'h01 -> ADATA; remaining = ulen-9.
  - Else -> DROP.
- VHDR:
  - 2 bytes latched into line_hdr, first byte in [15:8]; remaining -= 2.
  - Then VDATA, phase=Y.
- VDATA:
  - Bytes alternate Y then C.
  - On each C byte, vid_wr_en=1 for one cycle, registered one cycle after the C byte, with vid_din={line_hdr, Y, C}.
  - Write suppressed if vid_full=1 or max_vid_pairs already written; the pair is lost, not stalled.
  - If remaining reaches 0 on a Y byte, that odd byte is discarded.
  - remaining=0 -> TAIL.
- ADATA:
  - Each byte -> aux_wr_en=1, aux_din=byte, one cycle later.
  - Write suppressed while aux_full=1.
  - remaining=0 -> TAIL.
- TAIL: ignores bytes (FCS, padding) until rx_dv=0. Then frame_done pulse (and frame_err per the optional feature) -> IDLE.
- DROP: ignores bytes until rx_dv=0 -> IDLE.
- Abort:
  - rx_dv=0 in HDR, IDENT, VHDR, VDATA or ADATA -> frame_err pulse, drop_cnt+1, IDLE.
  - rx_er=1 in any non-idle state -> frame_err pulse, drop_cnt+1, WAIT_IDLE.
  - Writes already issued stay in the FIFO.
- Width rules: remaining is 16-bit unsigned; a decrement never underflows (guarded by the ulen >= 11 check).
- Latency: rxd sample to FIFO write is 1 cycle after the completing byte.

Optional Feature:
- Macro RX_CRC_CHECK_EN.
- Defined:
  - CRC-32 (poly 04C11DB7, init FFFFFFFF) runs over bytes from the first dst MAC byte through the FCS.
  - Residue checked at rx_dv fall in TAIL against 32'hC704DD7B.
  - Mismatch -> frame_err pulse instead of frame_done, and drop_cnt+1.
- Undefined: no CRC logic; TAIL always ends with frame_done.

Test Plan:
- Valid video frame: id=0, ulen=1291, hdr=16'h0123, 640 pairs Y=i, C=~i -> exactly 640 vid_wr_en, first vid_din=32'h012300FF, then frame_done=1, drop_cnt=0.
- Wrong dst MAC low byte (8'h03 with id=0) -> zero writes, drop_cnt=1, no frame_done.
- Audio frame: ident 8'h01, ulen=41 -> 32 aux_wr_en with bytes matching the sent data, then frame_done.
- vid_full held high for pairs 10-19 -> 630 writes; pair 20 carries Y=20, C=~20.
- rx_dv dropped after 100 video payload bytes -> frame_err pulse, drop_cnt+1; next valid frame is received fully.
- With RX_CRC_CHECK_EN: corrupt one FCS byte -> frame_err, drop_cnt+1. Without the macro: same frame -> frame_done.
